noc_input_port: RTL and testbench

Router input-port unit and requester side of the per-output round-robin arbiters. It buffers incoming spike flits in a small FIFO and decodes the destination output port from the head flit. It asserts a one-hot request toward that port's arbiter, pops the flit on grant and presents it on a registered output stage with valid/ready backpressure. One instance sits on each router input, and its `req` lines fan out to the arbiters of all output ports.

---
 rtl/noc_pkg.sv | 16 +
 rtl/noc_input_port_if.sv | 27 ++
 rtl/noc_flit_fifo.sv | 63 ++++++
 rtl/noc_input_port.sv | 166 ++++++++++++++++
 tb/tb_noc_input_port.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: input-port FSM state encoding and output-port indices.
// Used by the input ports, the router top and the per-output arbiters.
package noc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_STALL = 2'd2
    } noc_state_e;

    localparam logic [1:0] PORT_LOCAL = 2'd0;
    localparam logic [1:0] PORT_EAST  = 2'd1;
    localparam logic [1:0] PORT_WEST  = 2'd2;
    localparam logic [1:0] PORT_NORTH = 2'd3;

endpackage

// File: rtl/noc_input_port_if.sv
// Handshake bundle of one router input port: upstream flit in, arbiter req/gnt,
// and the registered flit stage toward the crossbar.
interface noc_input_port_if #(
    parameter int FLIT_W    = 32,
    parameter int NUM_PORTS = 4
) ();
    logic                 in_valid;
    logic [FLIT_W-1:0]    in_data;
    logic                 in_ready;
    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] gnt;
    logic                 out_valid;
    logic [FLIT_W-1:0]    out_data;
    logic                 out_ready;

    // Input-port unit side
    modport slave (
        input  in_valid, in_data, gnt, out_ready,
        output in_ready, req, out_valid, out_data
    );

    // Environment side: upstream link, arbiters and crossbar
    modport master (
        output in_valid, in_data, gnt, out_ready,
        input  in_ready, req, out_valid, out_data
    );
endinterface

// File: rtl/noc_flit_fifo.sv
// Synchronous flit FIFO with occupancy count; head is always visible on rdata.
// Push when full and pop when empty are ignored.
module noc_flit_fifo #(
    parameter int FLIT_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [FLIT_W-1:0]        wdata,
    input  logic                     pop,
    output logic [FLIT_W-1:0]        rdata,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [FLIT_W-1:0] mem_q [DEPTH];
    logic [FLIT_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push_s, do_pop_s;

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_d     = mem_q;
        do_push_s = push && (count_q != CW'(DEPTH));
        do_pop_s  = pop && (count_q != {CW{1'b0}});
        if (do_push_s) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d = count_q + CW'(do_push_s) - CW'(do_pop_s);
    end

    // FIFO state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {FLIT_W{1'b0}};
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
endmodule

// File: rtl/noc_input_port.sv
// Router input port: flit FIFO, head-port request decode, grant-driven pop into a
// registered output stage. Optional wait monitor enabled by NOC_IP_STARVE_MON_EN.
module noc_input_port
    import noc_pkg::*;
#(
    parameter int FLIT_W       = 32,
    parameter int NUM_PORTS    = 4,
    parameter int PORT_W       = 2,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    noc_input_port_if.slave         bus,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    drop,
    output logic                    starve
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int HW = 1 << PORT_W;

    noc_state_e           state_q, state_d;
    logic                 out_valid_q, out_valid_d;
    logic [FLIT_W-1:0]    out_data_q, out_data_d;

    logic                 push_s, pop_s, drop_s;
    logic [FLIT_W-1:0]    head_s;
    logic [CW-1:0]        fifo_count_s;
    logic [PORT_W-1:0]    hp_s;
    logic [HW-1:0]        hot_s;
    logic                 port_ok_s, out_free_s, grant_hit_s;
    logic                 has_data_s, more_s;
    logic [NUM_PORTS-1:0] req_s;

    noc_flit_fifo #(.FLIT_W(FLIT_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .wdata (bus.in_data),
        .pop   (pop_s),
        .rdata (head_s),
        .count (fifo_count_s)
    );

    assign bus.in_ready = (fifo_count_s != CW'(DEPTH));
    assign push_s       = bus.in_valid && bus.in_ready;

    // An index beyond NUM_PORTS lands outside the low slice of the one-hot
    assign hp_s        = head_s[FLIT_W-1 -: PORT_W];
    assign hot_s       = HW'(1) << hp_s;
    assign port_ok_s   = |hot_s[NUM_PORTS-1:0];
    assign out_free_s  = !out_valid_q || bus.out_ready;
    assign req_s       = (state_q == ST_REQ && port_ok_s && out_free_s) ?
                         hot_s[NUM_PORTS-1:0] : {NUM_PORTS{1'b0}};
    assign grant_hit_s = |(bus.gnt & req_s);
    assign has_data_s  = (fifo_count_s != {CW{1'b0}}) || push_s;
    assign more_s      = (fifo_count_s > CW'(1)) || push_s;

    // FSM next state, pop/drop decision and output-stage load
    always_comb begin
        state_d     = state_q;
        pop_s       = 1'b0;
        drop_s      = 1'b0;
        out_valid_d = out_valid_q && !bus.out_ready;
        out_data_d  = out_data_q;
        case (state_q)
            ST_IDLE: begin
                if (has_data_s && out_free_s) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (!port_ok_s) begin
                    pop_s   = 1'b1;
                    drop_s  = 1'b1;
                    state_d = more_s ? ST_REQ : ST_IDLE;
                end else if (!out_free_s) begin
                    state_d = ST_STALL;
                end else if (grant_hit_s) begin
                    pop_s       = 1'b1;
                    out_valid_d = 1'b1;
                    out_data_d  = head_s;
                    // A flit now sits in the output stage; keep requesting only if it drains
                    if (!more_s) begin
                        state_d = ST_IDLE;
                    end else if (bus.out_ready) begin
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_STALL;
                    end
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_STALL: begin
                if (out_free_s) begin
                    state_d = has_data_s ? ST_REQ : ST_IDLE;
                end else begin
                    state_d = ST_STALL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and registered output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= {FLIT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign bus.req       = req_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign count         = fifo_count_s;
    assign drop          = drop_s;

`ifdef NOC_IP_STARVE_MON_EN
    localparam int SW = $clog2(2 * STARVE_LIMIT + 1);
    localparam logic [SW-1:0] SAT_C   = SW'(2 * STARVE_LIMIT);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

    logic [SW-1:0] wait_q, wait_d;
    logic          starve_q, starve_d;

    // Saturating count of REQ cycles spent without a grant
    always_comb begin
        if (state_q == ST_REQ && (grant_hit_s || drop_s)) begin
            wait_d = {SW{1'b0}};
        end else if (state_q == ST_REQ && wait_q != SAT_C) begin
            wait_d = wait_q + SW'(1);
        end else begin
            wait_d = wait_q;
        end
        starve_d = (wait_d >= LIMIT_C);
    end

    // Wait counter and starvation flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q   <= {SW{1'b0}};
            starve_q <= 1'b0;
        end else begin
            wait_q   <= wait_d;
            starve_q <= starve_d;
        end
    end

    assign starve = starve_q;
`else
    logic unused_limit_s;
    assign unused_limit_s = (STARVE_LIMIT > 0);
    assign starve         = 1'b0;
`endif
endmodule

// File: tb/tb_noc_input_port.sv
// Self-checking bench for noc_input_port: scenario tasks plus an output scoreboard.
// A second instance with NUM_PORTS = 3 exercises the invalid-port drop path.
module tb_noc_input_port;
    import noc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    noc_input_port_if #(.FLIT_W(32), .NUM_PORTS(4)) bus ();
    noc_input_port_if #(.FLIT_W(32), .NUM_PORTS(3)) bus3 ();
    logic [2:0] count, count3;
    logic       drop, drop3, starve, starve3;

    noc_input_port #(.FLIT_W(32), .NUM_PORTS(4), .PORT_W(2), .DEPTH(4), .STARVE_LIMIT(16)) u_dut (
        .clk(clk), .rst(rst), .bus(bus), .count(count), .drop(drop), .starve(starve));
    noc_input_port #(.FLIT_W(32), .NUM_PORTS(3), .PORT_W(2), .DEPTH(4), .STARVE_LIMIT(16)) u_dut3 (
        .clk(clk), .rst(rst), .bus(bus3), .count(count3), .drop(drop3), .starve(starve3));

    int checks = 0;
    int failures = 0;
    int gnt_mode = 0;   // 0: none, 1: gnt = req, 2: every bit asserted
    logic [31:0] sb[$];
    logic [31:0] mon_exp;
    int ov_run = 0, ov_max = 0, ov_total = 0;

    always_comb begin
        case (gnt_mode)
            1:       bus.gnt = bus.req;
            2:       bus.gnt = 4'b1111;
            default: bus.gnt = 4'b0000;
        endcase
    end
    assign bus3.gnt = bus3.req;

    function automatic logic [31:0] mk(input logic [1:0] p, input int n);
        return {p, 30'(n)};
    endfunction

    // Scoreboard: every accepted output flit must match the oldest expected one
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            checks++;
            ov_total++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected got=%h", bus.out_data);
            end else begin
                mon_exp = sb.pop_front();
                if (bus.out_data !== mon_exp) begin
                    failures++;
                    $display("FAIL sb_data got=%h exp=%h", bus.out_data, mon_exp);
                end
            end
        end
        if (bus.out_valid) begin
            ov_run++;
            if (ov_run > ov_max) ov_max = ov_run;
        end else begin
            ov_run = 0;
        end
    end

    task automatic send(input logic [31:0] d);
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL send_timeout got=in_ready0 exp=accept");
        end else begin
            sb.push_back(d);
        end
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            done = (sb.size() == 0) && (count == 3'd0) && !bus.out_valid;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL drain_timeout got=sb%0d cnt%0d exp=empty", sb.size(), count);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = 32'd0; bus.out_ready = 1'b1;
        bus3.in_valid = 1'b0; bus3.in_data = 32'd0; bus3.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({count, bus.req, bus.out_valid, drop, starve, bus.in_ready} !== {3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_ctrl got=%b_%b_%b_%b_%b_%b exp=000_0000_0_0_0_1",
                     count, bus.req, bus.out_valid, drop, starve, bus.in_ready);
        end
        checks++;
        if (bus.out_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", bus.out_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [31:0] d = mk(2'd2, 123);
        gnt_mode = 1;
        bus.out_ready = 1'b1;
        send(d);
        @(negedge clk);
        checks++;
        if (bus.req !== 4'b0100 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_req got=%b/%b exp=0100/0", bus.req, bus.out_valid);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== d || count !== 3'd0) begin
            failures++;
            $display("FAIL single_out got=%b/%h/%0d exp=1/%h/0", bus.out_valid, bus.out_data, count, d);
        end
        @(posedge clk);
        #1;
        wait_drain();
    endtask

    task automatic test_fill();
        logic [1:0] ports [5] = '{2'd2, 2'd0, 2'd3, 2'd1, 2'd2};
        int acc = 0;
        bit ok;
        gnt_mode = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = mk(ports[i], 200 + i);
            @(negedge clk);
            ok = bus.in_ready;
            if (ok) begin
                acc++;
                sb.push_back(bus.in_data);
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (acc != 4) begin
            failures++;
            $display("FAIL fill_accepted got=%0d exp=4", acc);
        end
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0 || count !== 3'd4) begin
            failures++;
            $display("FAIL fill_full got=%b/%0d exp=0/4", bus.in_ready, count);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (bus.req !== 4'b0100) begin
                failures++;
                $display("FAIL fill_req_hold cyc=%0d got=%b exp=0100", i, bus.req);
            end
        end
`ifndef NOC_IP_STARVE_MON_EN
        checks++;
        if (starve !== 1'b0) begin
            failures++;
            $display("FAIL starve_tied got=%b exp=0", starve);
        end
`endif
        @(posedge clk);
        #1;
        gnt_mode = 1;
        wait_drain();
    endtask

    task automatic test_stall();
        logic [31:0] a = mk(2'd1, 301);
        logic [31:0] b = mk(2'd3, 302);
        gnt_mode = 1;
        bus.out_ready = 1'b0;
        send(a);
        send(b);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (u_dut.state_q !== ST_STALL || bus.req !== 4'b0000 || bus.out_data !== a || bus.out_valid !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold cyc=%0d got=%0d/%b/%h exp=STALL/0000/%h", i,
                         u_dut.state_q, bus.req, bus.out_data, a);
            end
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.req !== 4'b1000) begin
            failures++;
            $display("FAIL stall_resume_req got=%b exp=1000", bus.req);
        end
        @(posedge clk);
        #1;
        wait_drain();
    endtask

    task automatic test_back_to_back();
        logic [1:0] ports [4] = '{2'd0, 2'd1, 2'd3, 2'd1};
        gnt_mode = 2;
        bus.out_ready = 1'b1;
        ov_max = 0;
        ov_total = 0;
        for (int i = 0; i < 4; i++) send(mk(ports[i], 400 + i));
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (ov_max != 4 || ov_total != 4) begin
            failures++;
            $display("FAIL b2b_run got=%0d/%0d exp=4/4", ov_max, ov_total);
        end
        wait_drain();
        gnt_mode = 1;
    endtask

    task automatic test_invalid_port();
        logic [31:0] good = mk(2'd1, 501);
        bus3.out_ready = 1'b1;
        bus3.in_valid  = 1'b1;
        bus3.in_data   = mk(2'd3, 500);
        @(posedge clk);
        #1;
        bus3.in_data = good;
        @(negedge clk);
        checks++;
        if (drop3 !== 1'b1 || bus3.req !== 3'b000) begin
            failures++;
            $display("FAIL drop_pulse got=%b/%b exp=1/000", drop3, bus3.req);
        end
        @(posedge clk);
        #1;
        bus3.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (drop3 !== 1'b0 || bus3.req !== 3'b010) begin
            failures++;
            $display("FAIL drop_next_req got=%b/%b exp=0/010", drop3, bus3.req);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus3.out_valid !== 1'b1 || bus3.out_data !== good || count3 !== 3'd0) begin
            failures++;
            $display("FAIL drop_next_out got=%b/%h/%0d exp=1/%h/0", bus3.out_valid, bus3.out_data, count3, good);
        end
        @(posedge clk);
        #1;
    endtask

`ifdef NOC_IP_STARVE_MON_EN
    task automatic test_starve();
        gnt_mode = 0;
        bus.out_ready = 1'b1;
        send(mk(2'd0, 601));
        repeat (15) @(posedge clk);
        @(negedge clk);
        checks++;
        if (starve !== 1'b0) begin
            failures++;
            $display("FAIL starve_early got=%b exp=0", starve);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (starve !== 1'b1) begin
            failures++;
            $display("FAIL starve_set got=%b exp=1", starve);
        end
        gnt_mode = 1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (starve !== 1'b0) begin
            failures++;
            $display("FAIL starve_clear got=%b exp=0", starve);
        end
        @(posedge clk);
        #1;
        wait_drain();
    endtask
`endif

    task automatic test_reset_mid();
        gnt_mode = 1;
        bus.out_ready = 1'b0;
        send(mk(2'd2, 701));
        send(mk(2'd1, 702));
        send(mk(2'd0, 703));
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        @(negedge clk);
        checks++;
        if (count !== 3'd0 || bus.out_valid !== 1'b0 || bus.req !== 4'b0000 || bus.out_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid got=%0d/%b/%b/%h exp=0/0/0000/0", count, bus.out_valid, bus.req, bus.out_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_stall();
        test_back_to_back();
        test_invalid_port();
`ifdef NOC_IP_STARVE_MON_EN
        test_starve();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
